// File: rtl/phy_rx_serial_paralelo_pkg.sv
// Definitions shared by the lane serializer and receiver: comma symbol, lane width,
// receiver states and a saturating counter helper.
package phy_rx_serial_paralelo_pkg;

  localparam int          LANE_W          = 8;
  localparam logic [7:0]  COMMA           = 8'hBC;
  localparam logic [3:0]  COMMA_COUNT_DEF = 4'd4;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_LOCKING = 2'd1,
    ST_ACTIVE  = 2'd2
  } rx_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/phy_rx_serial_paralelo_if.sv
// Serial lane bundle: serial bit in, parallel byte and status out.
// Optional RX_BYTE_COUNT_EN adds the received data byte counter.
interface phy_rx_serial_paralelo_if;
  import phy_rx_serial_paralelo_pkg::*;

  logic              data_in;
  logic [LANE_W-1:0] data_out;
  logic              valid_out;
  logic              byte_strobe;
  logic              active;
`ifdef RX_BYTE_COUNT_EN
  logic [15:0]       rx_byte_count;
`endif

  // Serializer / lane demux side
  modport master (
    output data_in,
    input  data_out, valid_out, byte_strobe, active
`ifdef RX_BYTE_COUNT_EN
    , input rx_byte_count
`endif
  );

  // Receiver side
  modport slave (
    input  data_in,
    output data_out, valid_out, byte_strobe, active
`ifdef RX_BYTE_COUNT_EN
    , output rx_byte_count
`endif
  );

endinterface

// File: rtl/phy_rx_serial_paralelo.sv
// Single-lane serial-to-parallel receiver with comma alignment and lock.
// Optional RX_BYTE_COUNT_EN adds a saturating count of delivered data bytes.
module phy_rx_serial_paralelo
  import phy_rx_serial_paralelo_pkg::*;
#(
  parameter logic [7:0] COMMA_SYM   = COMMA,
  parameter logic [3:0] COMMA_COUNT = COMMA_COUNT_DEF
) (
  input  logic                     clk_32f,
  input  logic                     reset,
  phy_rx_serial_paralelo_if.slave  bus
);

  rx_state_e         r_state;
  logic [7:0]        r_sr;
  logic [2:0]        r_bit_cnt;
  logic [3:0]        r_comma_cnt;
  logic [LANE_W-1:0] r_data_out;
  logic              r_valid_out;
  logic              r_byte_strobe;
  logic              r_active;

  rx_state_e         w_state_nxt;
  logic [7:0]        w_win;
  logic              w_is_comma;
  logic              w_boundary;
  logic              w_slot_active;
  logic [2:0]        w_bit_cnt_nxt;
  logic [3:0]        w_comma_cnt_nxt;

  assign w_win      = {r_sr[6:0], bus.data_in};
  assign w_is_comma = (w_win == COMMA_SYM);
  assign w_boundary = (r_bit_cnt == 3'd7);

  // Next-state, comma counter and bit-phase logic
  always_comb begin
    w_state_nxt     = r_state;
    w_comma_cnt_nxt = r_comma_cnt;
    w_bit_cnt_nxt   = r_bit_cnt + 3'd1;
    w_slot_active   = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        // A comma at any bit offset sets the byte phase
        if (w_is_comma) begin
          w_bit_cnt_nxt   = 3'd0;
          w_comma_cnt_nxt = 4'd1;
          w_state_nxt     = (COMMA_COUNT <= 4'd1) ? ST_ACTIVE : ST_LOCKING;
        end else begin
          w_comma_cnt_nxt = 4'd0;
        end
      end
      ST_LOCKING: begin
        if (w_boundary) begin
          if (w_is_comma) begin
            w_comma_cnt_nxt = r_comma_cnt + 4'd1;
            if ((r_comma_cnt + 4'd1) >= COMMA_COUNT) begin
              w_state_nxt = ST_ACTIVE;
            end else begin
              w_state_nxt = ST_LOCKING;
            end
          end else begin
            w_comma_cnt_nxt = 4'd0;
            w_state_nxt     = ST_SEARCH;
          end
        end else begin
          w_state_nxt = ST_LOCKING;
        end
      end
      ST_ACTIVE: begin
        w_slot_active = w_boundary;
      end
      default: begin
        w_state_nxt     = ST_SEARCH;
        w_comma_cnt_nxt = 4'd0;
        w_bit_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State, shift register and counters
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_state     <= ST_SEARCH;
      r_sr        <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_comma_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_sr        <= w_win;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_comma_cnt <= w_comma_cnt_nxt;
    end
  end

  // Registered byte outputs; a comma slot drops valid but keeps the last data byte
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_data_out    <= 8'h00;
      r_valid_out   <= 1'b0;
      r_byte_strobe <= 1'b0;
      r_active      <= 1'b0;
    end else begin
      r_byte_strobe <= w_slot_active;
      r_active      <= (w_state_nxt == ST_ACTIVE);
      if (w_slot_active) begin
        if (w_is_comma) begin
          r_valid_out <= 1'b0;
        end else begin
          r_data_out  <= w_win;
          r_valid_out <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out    = r_data_out;
  assign bus.valid_out   = r_valid_out;
  assign bus.byte_strobe = r_byte_strobe;
  assign bus.active      = r_active;

`ifdef RX_BYTE_COUNT_EN
  logic [15:0] r_byte_count;

  // Counts data bytes delivered, saturating at all-ones
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_byte_count <= 16'h0000;
    end else if (w_slot_active && !w_is_comma) begin
      r_byte_count <= sat_inc16(r_byte_count);
    end
  end

  assign bus.rx_byte_count = r_byte_count;
`endif

endmodule
